// File: rtl/pipelined_exec_core.sv
// Two-stage issue/result core: decode and operand read into S1, ALU and commit into S2.
// Valid/ready handshakes on both sides, with forwarding from S1 to the instruction being accepted.
module pipelined_exec_core #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    output logic            inst_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_illegal,
    output logic            res_valid,
    input  logic            res_ready,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND
    } alu_op_t;

    typedef struct packed {
        alu_op_t         op;
        logic            ill;
        logic [4:0]      rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } id_ex_t;

    logic [XLEN-1:0] regs [32];
    id_ex_t          s1;
    logic            s1_valid;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign imm = XLEN'($signed(inst[31:20]));

    logic            s1_adv;
    logic            drain;
    logic            accept;

    assign drain      = res_valid && res_ready;
    assign s1_adv     = s1_valid && (!res_valid || res_ready);
    assign inst_ready = !s1_valid || s1_adv;
    assign accept     = inst_valid && inst_ready;

    alu_op_t d_op;
    logic    d_ill;
    logic    d_imm;

    always_comb begin
        d_op  = OP_ADD;
        d_ill = 1'b0;
        d_imm = 1'b0;
        unique case (1'b1)
            opc == 7'h01 && f3 == 3'd0: d_op = OP_ADD;
            opc == 7'h01 && f3 == 3'd1: d_op = OP_SUB;
            opc == 7'h03 && f3 == 3'd0: d_op = OP_SLL;
            opc == 7'h03 && f3 == 3'd1: d_op = OP_SRL;
            opc == 7'h03 && f3 == 3'd2: d_op = OP_SRA;
            opc == 7'h07 && f3 == 3'd0: d_op = OP_SLT;
            opc == 7'h07 && f3 == 3'd1: d_op = OP_SLTU;
            opc == 7'h0F && f3 == 3'd0: d_op = OP_XOR;
            opc == 7'h0F && f3 == 3'd1: d_op = OP_OR;
            opc == 7'h0F && f3 == 3'd2: d_op = OP_AND;
            opc == 7'h13 && f3 == 3'd0: d_imm = 1'b1;
            default:                    d_ill = 1'b1;
        endcase
    end

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_y;

    assign shamt = s1.b[SHAMT_W-1:0];

    always_comb begin
        alu_y = '0;
        case (s1.op)
            OP_ADD:  alu_y = s1.a + s1.b;
            OP_SUB:  alu_y = s1.a - s1.b;
            OP_SLL:  alu_y = s1.a << shamt;
            OP_SRL:  alu_y = s1.a >> shamt;
            OP_SRA:  alu_y = $signed(s1.a) >>> shamt;
            OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(s1.a) < $signed(s1.b)};
            OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, s1.a < s1.b};
            OP_XOR:  alu_y = s1.a ^ s1.b;
            OP_OR:   alu_y = s1.a | s1.b;
            OP_AND:  alu_y = s1.a & s1.b;
            default: alu_y = '0;
        endcase
    end

    // S1 commits on the same edge the new instruction is captured, so its result bypasses the regfile
    logic            fwd_ok;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;

    assign fwd_ok = s1_valid && !s1.ill && s1.rd != 5'd0;

    always_comb begin
        rv1 = regs[rs1];
        rv2 = regs[rs2];
        if (fwd_ok && s1.rd == rs1) rv1 = alu_y;
        if (fwd_ok && s1.rd == rs2) rv2 = alu_y;
        if (rs1 == 5'd0) rv1 = '0;
        if (rs2 == 5'd0) rv2 = '0;
    end

    id_ex_t d;

    always_comb begin
        d.op  = d_op;
        d.ill = d_ill;
        d.rd  = rd;
        d.a   = rv1;
        d.b   = d_imm ? imm : rv2;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1          <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_illegal <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (s1_adv) begin
                res_valid   <= 1'b1;
                res_data    <= s1.ill ? '0 : alu_y;
                res_rd      <= s1.rd;
                res_illegal <= s1.ill;
                if (!s1.ill && s1.rd != 5'd0) regs[s1.rd] <= alu_y;
            end else if (drain) begin
                res_valid <= 1'b0;
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1       <= d;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_pipelined_exec_core.sv
// Randomized and directed bench for pipelined_exec_core against an
// architectural, program-order reference model with a result queue.
module tb_pipelined_exec_core;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [31:0]     inst;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] res_data;
    logic [4:0]      res_rd;
    logic            res_illegal;
    logic            res_valid;
    logic            res_ready;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    pipelined_exec_core #(.XLEN(XLEN)) dut (
        .clock(clock), .reset_n(reset_n),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .res_data(res_data), .res_rd(res_rd), .res_illegal(res_illegal),
        .res_valid(res_valid), .res_ready(res_ready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mregs [32];
    exp_t        q [$];
    int          nchk = 0;
    int          nerr = 0;
    int          nacc = 0;
    int          ndrn = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rop(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] a,
                                        input logic [4:0] b);
        return {7'd0, b, a, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] a,
                                         input logic [11:0] imm);
        return {imm, a, 3'd0, rd, 7'h13};
    endfunction

    // Architectural effect of one instruction on the program-order register state
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        int          sh;
        a      = mregs[ins[19:15]];
        b      = mregs[ins[24:20]];
        im     = {{20{ins[31]}}, ins[31:20]};
        sh     = int'(b % 32);
        e.rd   = ins[11:7];
        e.ill  = 1'b0;
        e.data = 32'd0;
        case ({ins[6:0], ins[14:12]})
            {7'h01, 3'd0}: e.data = a + b;
            {7'h01, 3'd1}: e.data = a - b;
            {7'h03, 3'd0}: e.data = a << sh;
            {7'h03, 3'd1}: e.data = a >> sh;
            {7'h03, 3'd2}: e.data = 32'($signed(a) >>> sh);
            {7'h07, 3'd0}: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            {7'h07, 3'd1}: e.data = (a < b) ? 32'd1 : 32'd0;
            {7'h0F, 3'd0}: e.data = a ^ b;
            {7'h0F, 3'd1}: e.data = a | b;
            {7'h0F, 3'd2}: e.data = a & b;
            {7'h13, 3'd0}: e.data = a + im;
            default:       e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic rr);
        exp_t e;
        @(negedge clock);
        inst_valid = v;
        inst       = ins;
        res_ready  = rr;
        #1;
        if (res_valid && res_ready) begin
            ndrn++;
            if (q.size() == 0) begin
                check("spurious_result", 64'(res_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("res_rd", 64'(res_rd), 64'(e.rd));
                check("res_data", 64'(res_data), 64'(e.data));
                check("res_illegal", 64'(res_illegal), 64'(e.ill));
            end
        end
        if (inst_valid && inst_ready) begin
            nacc++;
            e = model(ins);
            if (!e.ill && e.rd != 5'd0) mregs[e.rd] = e.data;
            q.push_back(e);
        end
        @(posedge clock);
    endtask

    task automatic offer(input logic [31:0] ins);
        int a0;
        int n;
        a0 = nacc;
        n  = 0;
        while (nacc == a0 && n < 20) begin
            step(1'b1, ins, 1'b1);
            n++;
        end
        if (nacc == a0) check("offer_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            step(1'b0, 32'd0, 1'b1);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
        #1;
        check("idle_valid", 64'(res_valid), 64'd0);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, 64'(dbg_data), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        inst_valid = 1'b0;
        res_ready  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        #1;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0]  ops [5];
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  a;
        logic [4:0]  b;
        ops = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h13};
        op  = ops[$urandom_range(0, 4)];
        f3  = 3'($urandom_range(0, 2));
        rd  = 5'($urandom_range(0, 7));
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) op = 7'($urandom);
        if (op == 7'h13) return addi(rd, a, 12'($urandom));
        return rop(op, f3, rd, a, b);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int d0;
        logic [31:0] bp [3];
        reset_n    = 1'b0;
        inst       = 32'd0;
        inst_valid = 1'b0;
        res_ready  = 1'b0;
        dbg_addr   = 5'd0;
        repeat (2) @(posedge clock);
        do_reset();
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_rd", 64'(res_rd), 64'd0);
        check("rst_res_illegal", 64'(res_illegal), 64'd0);
        check("rst_inst_ready", 64'(inst_ready), 64'd1);

        // forwarding chain with latency checks
        step(1'b1, addi(5'd1, 5'd0, 12'd15), 1'b1);
        #1 check("lat_n", 64'(res_valid), 64'd0);
        step(1'b1, addi(5'd2, 5'd0, 12'd12), 1'b1);
        #1 check("lat_n1", 64'(res_valid), 64'd1);
        step(1'b1, rop(7'h01, 3'd0, 5'd7, 5'd1, 5'd2), 1'b1);
        step(1'b1, rop(7'h01, 3'd1, 5'd8, 5'd1, 5'd2), 1'b1);
        check("thruput", 64'(nacc), 64'd4);
        drain();
        dbg(5'd7, 32'h1B, "fwd_r7");
        dbg(5'd8, 32'h3, "fwd_r8");

        // shifts and compares
        offer(addi(5'd3, 5'd0, 12'hFFF));
        offer(addi(5'd6, 5'd0, 12'd4));
        offer(rop(7'h03, 3'd0, 5'd9, 5'd3, 5'd6));
        offer(rop(7'h03, 3'd1, 5'd10, 5'd3, 5'd6));
        offer(rop(7'h03, 3'd2, 5'd11, 5'd3, 5'd6));
        offer(rop(7'h07, 3'd0, 5'd12, 5'd3, 5'd1));
        offer(rop(7'h07, 3'd1, 5'd13, 5'd3, 5'd1));
        offer(rop(7'h0F, 3'd0, 5'd14, 5'd1, 5'd2));
        offer(rop(7'h0F, 3'd1, 5'd15, 5'd1, 5'd2));
        offer(rop(7'h0F, 3'd2, 5'd16, 5'd1, 5'd2));
        drain();
        dbg(5'd9, 32'hFFFFFFF0, "sll");
        dbg(5'd10, 32'h0FFFFFFF, "srl");
        dbg(5'd11, 32'hFFFFFFFF, "sra");
        dbg(5'd12, 32'd1, "slt");
        dbg(5'd13, 32'd0, "sltu");
        dbg(5'd14, 32'h3, "xor");
        dbg(5'd15, 32'hF, "or");
        dbg(5'd16, 32'hC, "and");

        // backpressure with a dependent chain
        bp[0] = addi(5'd17, 5'd0, 12'd100);
        bp[1] = rop(7'h01, 3'd0, 5'd18, 5'd17, 5'd17);
        bp[2] = rop(7'h01, 3'd1, 5'd19, 5'd18, 5'd1);
        a0 = nacc;
        d0 = ndrn;
        for (int i = 0; i < 4; i++) step(1'b1, bp[nacc - a0], 1'b0);
        #1;
        check("bp_accepted", 64'(nacc - a0), 64'd2);
        check("bp_inst_ready", 64'(inst_ready), 64'd0);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 10 && nacc - a0 < 3; i++) step(1'b1, bp[nacc - a0], 1'b1);
        check("bp_all_accepted", 64'(nacc - a0), 64'd3);
        drain();
        check("bp_results", 64'(ndrn - d0), 64'd3);
        dbg(5'd19, 32'd185, "bp_r19");

        // illegal instruction
        offer(addi(5'd5, 5'd0, 12'd15));
        offer({7'd0, 5'd1, 5'd2, 3'd0, 5'd5, 7'h7F});
        offer(rop(7'h01, 3'd0, 5'd20, 5'd5, 5'd5));
        drain();
        dbg(5'd5, 32'hF, "ill_r5");
        dbg(5'd20, 32'h1E, "ill_next");

        // x0 protection
        offer(addi(5'd0, 5'd0, 12'd5));
        offer(rop(7'h01, 3'd0, 5'd9, 5'd0, 5'd0));
        drain();
        dbg(5'd0, 32'd0, "x0");
        dbg(5'd9, 32'd0, "x0_add");

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), rnd_inst(), 1'($urandom_range(0, 2) != 0));
        drain();
        for (int r = 0; r < 32; r++) dbg(5'(r), mregs[r], "rand_reg");

        // reset with both stages full
        step(1'b1, addi(5'd21, 5'd0, 12'd7), 1'b0);
        step(1'b1, addi(5'd22, 5'd0, 12'd9), 1'b0);
        #1 check("mid_full", 64'(inst_ready), 64'd0);
        do_reset();
        check("mid_res_valid", 64'(res_valid), 64'd0);
        check("mid_inst_ready", 64'(inst_ready), 64'd1);
        for (int r = 0; r < 32; r++) dbg(5'(r), 32'd0, "mid_reg_clear");
        d0 = ndrn;
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
        check("mid_no_result", 64'(ndrn - d0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipelined_exec_core.md
Name: pipelined_exec_core

Overview:
- Parametrised successor to the single-cycle 32-bit register-bank + ALU processor.
- Two-stage issue/result pipeline with valid/ready handshakes on both the instruction and result sides.
- Operand forwarding, a new ADDI immediate op and illegal-instruction flagging.
- XLEN-wide datapath; 32-entry register bank; debug read port for verification.

Parameters:
- XLEN, 32, datapath and register width; power of two, ≥8.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- inst  in  32  instruction word.
- inst_valid  in  1  inst is presented.
- inst_ready  out  1  core accepts inst this cycle.
- res_data  out  XLEN  result of the oldest completed instruction.
- res_rd  out  5  destination register of res_data.
- res_illegal  out  1  instruction was undecodable.
- res_valid  out  1  result fields are valid.
- res_ready  in  1  consumer takes the result this cycle.
- dbg_addr  in  5  debug register index.
- dbg_data  out  XLEN  combinational read of regfile[dbg_addr].

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clock, reset_n).
- Instruction format: [31:25] funct7 (ignored), [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode.
- Opcode/funct3 decode:
  - 0x01: 0 ADD, 1 SUB.
  - 0x03: 0 SLL, 1 SRL, 2 SRA.
  - 0x07: 0 SLT (signed), 1 SLTU.
  - 0x0F: 0 XOR, 1 OR, 2 AND.
  - 0x13: 0 ADDI, where rd = rs1 + sign-extend(inst[31:20]) to XLEN.
  - Any other combination is illegal.
- Arithmetic: all ops modulo 2^XLEN. Shifts use rs2[SHAMT_W-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
- Pipeline registers:
  - S1 holds the decoded op, operands and rd.
  - S2 holds res_data, res_rd and res_illegal.
  - Each stage has its own valid flag.
- Handshake and advance rules:
  - S2 drains when res_valid && res_ready.
  - S1 advances when S1 is valid && (!res_valid || res_ready).
  - inst_ready = !S1valid || S1advances.
  - An instruction is accepted when inst_valid && inst_ready.
- Latency and throughput:
  - An instruction accepted at edge N drives res_valid=1 after edge N+1.
  - With res_ready held high, throughput is 1 per cycle.
  - Results appear strictly in order.
- Commit: the regfile is written at the edge where S1 advances into S2.
  - No write when rd=0 (x0 always reads 0).
  - No write when the instruction is illegal.
- Illegal instructions: res_data=0, res_illegal=1, res_rd=rd; the instruction still occupies both stages.
- Operand read at accept:
  - Read from the regfile.
  - If S1 is valid, S1 is legal, S1.rd≠0 and S1.rd matches rs1/rs2, use the S1 ALU output (forwarding).
  - rs=0 always yields 0.
- Stall: S1 and S2 contents hold stable while stalled. If a dependent instruction is not accepted, forwarding is re-evaluated each cycle.
- Simultaneous events:
  - Accept and S1 advance on the same edge: S1 reloads with the new instruction.
  - S2 drain and refill on the same edge: S2 reloads.
- Reset (asserted on any edge, including mid-operation):
  - Both valid flags clear; in-flight instructions are discarded with no commit.
  - All 32 registers clear to 0.
  - Outputs: res_data=0, res_rd=0, res_illegal=0, res_valid=0.
  - inst_ready=1 on the first cycle after reset is released.
- dbg_data reflects committed state only (no forwarding).

Test Plan:
- Forwarding chain: reset, res_ready=1, back-to-back ADDI r1,r0,15 / ADDI r2,r0,12 / ADD r7,r1,r2 / SUB r8,r1,r2.
  - Results in order: (1,0xF), (2,0xC), (7,0x1B), (8,0x3).
  - dbg r7=0x1B.
- Shift/compare: ADDI r3,r0,-1 and ADDI r6,r0,4, then SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND.
  - SLL r9,r3,r6 → 0xFFFFFFF0.
  - SRL r10 → 0x0FFFFFFF.
  - SRA r11 → 0xFFFFFFFF.
  - SLT r12,r3,r1 → 1.
  - SLTU r13,r3,r1 → 0.
  - XOR r14,r1,r2 → 0x3; OR → 0xF; AND → 0xC.
- Backpressure: res_ready=0, offer 3 instructions.
  - Exactly 2 are accepted; inst_ready=0 while both stages are full.
  - Raise res_ready: all 3 results arrive in order, none lost or duplicated.
- Illegal: opcode 0x7F, rd=5, with r5=0xF.
  - res_illegal=1, res_data=0, res_rd=5; dbg r5 stays 0xF.
  - A following legal op reports res_illegal=0.
- x0 protection: ADDI r0,r0,5 → result (0,5) reported, dbg r0=0. Following ADD r9,r0,r0 → 0.
- Reset mid-flight: both stages full, res_ready=0, pulse reset_n=0 for one edge.
  - Next cycle: res_valid=0, inst_ready=1, dbg of every register=0.
  - No further result emitted for the discarded instructions.
